// File: rtl/nes_frame_capture_if.sv
// +----------------------------------------------------------------------------+
// | nes_frame_capture_if                                                       |
// | Pixel stream in / frame-buffer write bus out for nes_frame_capture.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface nes_frame_capture_if;
  logic        rendering;
  logic        frame_start;
  logic [5:0]  color;
  logic        wr;
  logic [15:0] wr_addr;
  logic [5:0]  wr_data;
  logic        frame_done;
  logic        frame_err;
  logic [7:0]  frame_count;

  // master: PPU-side source; slave: the capture block
  modport master (
    output rendering, frame_start, color,
    input  wr, wr_addr, wr_data, frame_done, frame_err, frame_count
  );

  modport slave (
    input  rendering, frame_start, color,
    output wr, wr_addr, wr_data, frame_done, frame_err, frame_count
  );
endinterface

`default_nettype wire

// File: rtl/nes_frame_capture.sv
// +----------------------------------------------------------------------------+
// | nes_frame_capture                                                          |
// | PPU pixel stream to linear frame-buffer writes with frame alignment/errors.|
// | Optional: CAPTURE_OVERSCAN_EN blanks the top/bottom 8 rows to 6'h0F.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module nes_frame_capture #(
  parameter int H_PIXELS = 256,
  parameter int V_LINES  = 240
) (
  input  wire                  ppu_clock,
  input  wire                  rst_n,
  nes_frame_capture_if.slave   bus
);

  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = 16 - XW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic           wr_q, wr_d;
  logic [15:0]    addr_q, addr_d;
  logic [5:0]     data_q, data_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [7:0]     cnt_q, cnt_d;

  logic           w_x_last;
  logic           w_last_px;
  logic [5:0]     w_pix;

  assign w_x_last  = (x_q == XW'(H_PIXELS - 1));
  assign w_last_px = w_x_last && (y_q == YW'(V_LINES - 1));

`ifdef CAPTURE_OVERSCAN_EN
  assign w_pix = ((y_q < YW'(8)) || (y_q >= YW'(V_LINES - 8))) ? 6'h0F : bus.color;
`else
  assign w_pix = bus.color;
`endif

  always_ff @(posedge ppu_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.frame_start) begin
          x_d     = '0;
          y_d     = '0;
          state_d = S_CAPTURE;
        end else if (bus.rendering) begin
          err_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (bus.frame_start) begin
          // Short frame: restart alignment, the pixel in this cycle is dropped
          err_d = 1'b1;
          x_d   = '0;
          y_d   = '0;
        end else if (bus.rendering) begin
          wr_d   = 1'b1;
          addr_d = {y_q, x_q};
          data_d = w_pix;
          if (w_last_px) begin
            x_d     = '0;
            y_d     = '0;
            state_d = S_DONE;
          end else if (w_x_last) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        cnt_d  = cnt_q + 8'd1;
        err_d  = 1'b0;
        x_d    = '0;
        y_d    = '0;
        if (bus.frame_start) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_IDLE;
          if (bus.rendering) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ppu_clock or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      wr_q   <= 1'b0;
      addr_q <= 16'h0000;
      data_q <= 6'h00;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= 8'h00;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      done_q <= done_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.wr          = wr_q;
  assign bus.wr_addr     = addr_q;
  assign bus.wr_data     = data_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_err   = err_q;
  assign bus.frame_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_frame_capture.sv
// +----------------------------------------------------------------------------+
// | tb_nes_frame_capture                                                       |
// | Directed vector table plus multi-cycle frame sequences for the capture.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_nes_frame_capture;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  nes_frame_capture_if bus ();

  nes_frame_capture #(
    .H_PIXELS (256),
    .V_LINES  (240)
  ) dut (
    .ppu_clock (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic        r;
    logic        fs;
    logic [5:0]  c;
    logic        wr;
    logic [15:0] addr;
    logic [5:0]  data;
    logic        err;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected write data for a pixel at linear address a with color c
  function automatic logic [5:0] exp_data(input logic [15:0] a, input logic [5:0] c);
`ifdef CAPTURE_OVERSCAN_EN
    if ((a[15:8] < 8'd8) || (a[15:8] >= 8'd232)) return 6'h0F;
`endif
    return c;
  endfunction

  task automatic step(input logic r, input logic fs, input logic [5:0] c);
    bus.rendering   = r;
    bus.frame_start = fs;
    bus.color       = c;
    @(posedge clk);
    #1;
  endtask

  // Streams n pixels starting at address 0 with color = x[5:0]; an idle cycle
  // follows each pixel below gap_lo and from gap_hi up to (not incl.) the last.
  task automatic stream(input int n, input int gap_lo, input int gap_hi, input string name);
    int bad = 0;
    logic [15:0] a;
    for (int p = 0; p < n; p++) begin
      a = 16'(p);
      step(1'b1, 1'b0, a[5:0]);
      if (bus.wr !== 1'b1 || bus.wr_addr !== a || bus.wr_data !== exp_data(a, a[5:0])
          || bus.frame_done !== 1'b0) begin
        if (bad == 0) $display("first bad write at pixel %0d: wr=%b addr=%h data=%h", p,
                               bus.wr, bus.wr_addr, bus.wr_data);
        bad++;
      end
      if (p < gap_lo || (p >= gap_hi && p < n - 1)) begin
        step(1'b0, 1'b0, 6'h3F);
        if (bus.wr !== 1'b0 || bus.wr_addr !== a || bus.frame_done !== 1'b0) bad++;
      end
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    bus.rendering   = 1'b0;
    bus.frame_start = 1'b0;
    bus.color       = 6'h00;

    //           r     fs    c      wr    addr      data   err
    vt[0]  = '{1'b0, 1'b0, 6'h00, 1'b0, 16'h0000, 6'h00, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 6'h3F, 1'b0, 16'h0000, 6'h00, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 6'h3E, 1'b0, 16'h0000, 6'h00, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 6'h3D, 1'b0, 16'h0000, 6'h00, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 6'h3C, 1'b0, 16'h0000, 6'h00, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 6'h3B, 1'b0, 16'h0000, 6'h00, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 6'h2A, 1'b0, 16'h0000, 6'h00, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 6'h11, 1'b1, 16'h0000, 6'h11, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 6'h22, 1'b0, 16'h0000, 6'h11, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 6'h05, 1'b1, 16'h0001, 6'h05, 1'b1};
    vt[10] = '{1'b1, 1'b0, 6'h06, 1'b1, 16'h0002, 6'h06, 1'b1};
    vt[11] = '{1'b1, 1'b1, 6'h07, 1'b0, 16'h0002, 6'h06, 1'b1};
    vt[12] = '{1'b1, 1'b0, 6'h08, 1'b1, 16'h0000, 6'h08, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr",    32'(bus.wr),          32'd0);
    chk("rst_addr",  32'(bus.wr_addr),     32'd0);
    chk("rst_data",  32'(bus.wr_data),     32'd0);
    chk("rst_done",  32'(bus.frame_done),  32'd0);
    chk("rst_err",   32'(bus.frame_err),   32'd0);
    chk("rst_count", 32'(bus.frame_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      step(vt[i].r, vt[i].fs, vt[i].c);
      chk($sformatf("vec%0d_wr", i),   32'(bus.wr),         32'(vt[i].wr));
      chk($sformatf("vec%0d_addr", i), 32'(bus.wr_addr),    32'(vt[i].addr));
      chk($sformatf("vec%0d_data", i), 32'(bus.wr_data),    32'(exp_data(vt[i].addr, vt[i].data)));
      chk($sformatf("vec%0d_err", i),  32'(bus.frame_err),  32'(vt[i].err));
      chk($sformatf("vec%0d_done", i), 32'(bus.frame_done), 32'd0);
    end

    // Restart alignment, then a whole frame with gaps at both ends
    step(1'b0, 1'b1, 6'h00);
    chk("restart_wr", 32'(bus.wr), 32'd0);
    stream(61440, 512, 60928, "full_frame_seq");
    chk("last_addr", 32'(bus.wr_addr), 32'hEFFF);
    // frame_start during the DONE cycle goes straight back to CAPTURE
    step(1'b0, 1'b1, 6'h00);
    chk("frame_done",      32'(bus.frame_done),  32'd1);
    chk("frame_count_1",   32'(bus.frame_count), 32'd1);
    chk("err_cleared",     32'(bus.frame_err),   32'd0);
    chk("done_cycle_wr",   32'(bus.wr),          32'd0);

    stream(1000, 0, 1000, "short_frame_seq");
    chk("short_err_before", 32'(bus.frame_err), 32'd0);
    step(1'b1, 1'b1, 6'h3F);
    chk("short_err",  32'(bus.frame_err),  32'd1);
    chk("short_done", 32'(bus.frame_done), 32'd0);
    chk("short_wr",   32'(bus.wr),         32'd0);
    chk("short_cnt",  32'(bus.frame_count), 32'd1);

    // Restarted frame from address 0, aborted by reset at pixel (10,4)
    stream(1034, 0, 1034, "restart_seq");
    bus.rendering   = 1'b1;
    bus.frame_start = 1'b0;
    bus.color       = 6'h0A;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr",    32'(bus.wr),          32'd0);
    chk("midrst_count", 32'(bus.frame_count), 32'd0);
    chk("midrst_err",   32'(bus.frame_err),   32'd0);
    chk("midrst_addr",  32'(bus.wr_addr),     32'd0);
    chk("midrst_done",  32'(bus.frame_done),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 6'h01);
      chk($sformatf("postrst_idle_wr%0d", i), 32'(bus.wr),        32'd0);
      chk($sformatf("postrst_err%0d", i),     32'(bus.frame_err), 32'd1);
    end
    step(1'b0, 1'b1, 6'h00);
    step(1'b1, 1'b0, 6'h15);
    chk("postrst_first_wr",   32'(bus.wr),      32'd1);
    chk("postrst_first_addr", 32'(bus.wr_addr), 32'd0);
    chk("postrst_first_data", 32'(bus.wr_data), 32'(exp_data(16'h0000, 6'h15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
